// File: rtl/branchwb_arbiter_pkg.sv
// Shared types for the branch-writeback arbiter: ROB age tag, writeback payload,
// FSM states and the wrap-aware age compare.
package branchwb_arbiter_pkg;

    localparam int ROB_IDX_W = 6;
    localparam int FTQ_IDX_W = 4;
    localparam int OFFSET_W  = 3;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef enum logic [1:0] {
        BR_COND,
        BR_JAL,
        BR_JALR,
        BR_RET
    } branch_type_t;

    typedef struct packed {
        branch_type_t         branch_type;
        robIdx_t              rob_idx;
        logic [FTQ_IDX_W-1:0] ftq_idx;
        logic                 has_mispred;
        logic                 branch_taken;
        logic [OFFSET_W-1:0]  fallthruOffset;
        logic [PC_W-1:0]      target_pc;
        logic [PC_W-1:0]      branch_npc;
    } branchwbInfo_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISSUED
    } BrwbState_t;

    // The flag bit toggles on every ROB wrap, so differing flags invert the index order.
    function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
        return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/branchwb_arbiter_if.sv
// Writeback/squash bundle between the BRU pipes, the arbiter and the redirect logic.
// master = BRU writeback side plus squash consumer, slave = arbiter.
interface branchwb_arbiter_if
    import branchwb_arbiter_pkg::*;
#(
    parameter int BRWB_PORTS = 2
);
    logic [BRWB_PORTS-1:0] i_branchwb_vld;
    branchwbInfo_t         i_branchwbInfo [BRWB_PORTS];
    logic                  o_squash_vld;
    branchwbInfo_t         o_squash_info;
    logic                  i_squash_rdy;
    logic                  i_redirect_done;
    logic                  o_busy;

    modport master (
        output i_branchwb_vld,
        output i_branchwbInfo,
        output i_squash_rdy,
        output i_redirect_done,
        input  o_squash_vld,
        input  o_squash_info,
        input  o_busy
    );

    modport slave (
        input  i_branchwb_vld,
        input  i_branchwbInfo,
        input  i_squash_rdy,
        input  i_redirect_done,
        output o_squash_vld,
        output o_squash_info,
        output o_busy
    );
endinterface

// File: rtl/branchwb_arbiter_oldest_select.sv
// Picks the oldest valid mispredict among BRWB_PORTS writebacks and counts how many
// mispredicts arrived this cycle.
module oldest_select
    import branchwb_arbiter_pkg::*;
#(
    parameter int BRWB_PORTS = 2,
    parameter int NUM_W      = $clog2(BRWB_PORTS + 1)
) (
    input  logic [BRWB_PORTS-1:0] vld,
    input  branchwbInfo_t         info [BRWB_PORTS],
    output logic                  cand_vld,
    output branchwbInfo_t         cand,
    output logic [NUM_W-1:0]      mispred_num
);

    // NOTE: every output gets a default before the loop so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        cand_vld    = 1'b0;
        cand        = '0;
        mispred_num = '0;
        for (int i = 0; i < BRWB_PORTS; i++) begin
            if (vld[i] && info[i].has_mispred) begin
                mispred_num = mispred_num + NUM_W'(1);
                if (!cand_vld || rob_older(info[i].rob_idx, cand.rob_idx)) begin
                    cand_vld = 1'b1;
                    cand     = info[i];
                end
            end
        end
    end

endmodule

// File: rtl/branchwb_arbiter.sv
// Keeps the single oldest outstanding branch mispredict and offers it as a squash request.
// Optional statistics counters are enabled by defining BRANCHWB_STAT_EN.
module branchwb_arbiter
    import branchwb_arbiter_pkg::*;
#(
    parameter int BRWB_PORTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    branchwb_arbiter_if.slave bus
`ifdef BRANCHWB_STAT_EN
    ,
    output logic [63:0]       o_mispred_cnt,
    output logic [63:0]       o_drop_cnt
`endif
);

    localparam int NUM_W = $clog2(BRWB_PORTS + 1);

    logic             cand_vld;
    branchwbInfo_t    cand;
    logic [NUM_W-1:0] mispred_num;

    BrwbState_t       state_q, state_d;
    branchwbInfo_t    held_q, held_d;
    robIdx_t          issued_rob_q, issued_rob_d;
    logic             issued_vld_q, issued_vld_d;
    logic             accept;
    logic             handshake;

    oldest_select #(
        .BRWB_PORTS(BRWB_PORTS),
        .NUM_W     (NUM_W)
    ) u_oldest_select (
        .vld        (bus.i_branchwb_vld),
        .info       (bus.i_branchwbInfo),
        .cand_vld   (cand_vld),
        .cand       (cand),
        .mispred_num(mispred_num)
    );

    assign handshake = (state_q == PEND) && bus.i_squash_rdy;

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        issued_rob_d = issued_rob_q;
        issued_vld_d = issued_vld_q;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    held_d  = cand;
                    accept  = 1'b1;
                    state_d = PEND;
                end
            end

            PEND: begin
                if (bus.i_redirect_done) begin
                    issued_vld_d = 1'b0;
                end
                if (cand_vld && rob_older(cand.rob_idx, held_q.rob_idx)) begin
                    held_d = cand;
                    accept = 1'b1;
                end
                // A handshake issues the entry held before this edge, even if it is replaced.
                if (handshake) begin
                    issued_rob_d = held_q.rob_idx;
                    issued_vld_d = 1'b1;
                    if (!accept) begin
                        state_d = ISSUED;
                    end
                end
            end

            ISSUED: begin
                if (bus.i_redirect_done) begin
                    issued_vld_d = 1'b0;
                    state_d      = IDLE;
                end else if (cand_vld &&
                             (!issued_vld_q || rob_older(cand.rob_idx, issued_rob_q))) begin
                    held_d  = cand;
                    accept  = 1'b1;
                    state_d = PEND;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issued_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_vld_q <= issued_vld_d;
        end
    end

    // NOTE: the held payload and filter tag are data only, qualified by state_q and
    // issued_vld_q, so they are deliberately left out of reset.
    always_ff @(posedge clk) begin
        held_q       <= held_d;
        issued_rob_q <= issued_rob_d;
    end

    assign bus.o_squash_vld  = (state_q == PEND);
    assign bus.o_squash_info = held_q;
    assign bus.o_busy        = (state_q != IDLE);

`ifdef BRANCHWB_STAT_EN
    logic [NUM_W-1:0] drop_num;

    // Every mispredict seen this cycle that was not latched counts as dropped.
    assign drop_num = mispred_num - NUM_W'(accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mispred_cnt <= '0;
            o_drop_cnt    <= '0;
        end else begin
            o_mispred_cnt <= o_mispred_cnt + 64'(handshake);
            o_drop_cnt    <= o_drop_cnt + 64'(drop_num);
        end
    end
`endif

endmodule

// File: tb/tb_branchwb_arbiter.sv
// Directed self-checking bench for branchwb_arbiter; counter checks compile in only
// when BRANCHWB_STAT_EN is defined.
module tb_branchwb_arbiter;
    import branchwb_arbiter_pkg::*;

    localparam int PORTS = 2;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PEND = 2'b11;
    localparam logic [1:0] S_ISS  = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] exp_mispred = '0;
    logic [63:0] exp_drop    = '0;

    always #5 clk = ~clk;

    branchwb_arbiter_if #(.BRWB_PORTS(PORTS)) bus ();

`ifdef BRANCHWB_STAT_EN
    logic [63:0] mispred_cnt;
    logic [63:0] drop_cnt;
`endif

    branchwb_arbiter #(.BRWB_PORTS(PORTS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BRANCHWB_STAT_EN
        ,
        .o_mispred_cnt(mispred_cnt),
        .o_drop_cnt(drop_cnt)
`endif
    );

    function automatic branchwbInfo_t mk(input logic flag, input logic [ROB_IDX_W-1:0] idx);
        branchwbInfo_t r;
        r                = '0;
        r.branch_type    = BR_COND;
        r.rob_idx.flag   = flag;
        r.rob_idx.idx    = idx;
        r.ftq_idx        = idx[FTQ_IDX_W-1:0];
        r.has_mispred    = 1'b1;
        r.branch_taken   = 1'b1;
        r.fallthruOffset = 3'd4;
        r.target_pc      = 32'h8000_0000 + {25'd0, flag, idx} * 32'd16;
        r.branch_npc     = 32'h4000_0000 + {25'd0, flag, idx};
        return r;
    endfunction

    function automatic logic [1:0] st();
        return {bus.o_squash_vld, bus.o_busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input branchwbInfo_t info);
        bus.i_branchwb_vld[p] = 1'b1;
        bus.i_branchwbInfo[p] = info;
    endtask

    task automatic idle_inputs();
        bus.i_branchwb_vld  = '0;
        for (int i = 0; i < PORTS; i++) bus.i_branchwbInfo[i] = '0;
        bus.i_squash_rdy    = 1'b0;
        bus.i_redirect_done = 1'b0;
    endtask

    // Hand off the held request, then complete the redirect.
    task automatic drain();
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_squash_rdy    = 1'b0;
        bus.i_redirect_done = 1'b1;
        exp_mispred++;
        step();
        bus.i_redirect_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %b want %b", st(), S_IDLE); end
        set_port(0, mk(1'b0, 6'd5));
        step();
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL reset_priority: got %b want %b", st(), S_IDLE); end
`ifdef BRANCHWB_STAT_EN
        n_checks++; if (mispred_cnt !== 64'd0 || drop_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", mispred_cnt, drop_cnt); end
`endif
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_port(0, mk(1'b0, 6'd5));
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_branchwb_vld = '0;
        n_checks++; if (st() !== S_PEND) begin n_fail++; $display("FAIL single_vld: got %b want %b", st(), S_PEND); end
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd5)) begin n_fail++; $display("FAIL single_info: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd5)); end
        step();
        exp_mispred++;
        n_checks++; if (st() !== S_ISS) begin n_fail++; $display("FAIL single_issued: got %b want %b", st(), S_ISS); end
        bus.i_squash_rdy    = 1'b0;
        bus.i_redirect_done = 1'b1;
        step();
        bus.i_redirect_done = 1'b0;
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL single_done: got %b want %b", st(), S_IDLE); end
    endtask

    task automatic test_no_mispred_filter();
        branchwbInfo_t info;
        info = mk(1'b0, 6'd6);
        info.has_mispred = 1'b0;
        set_port(1, info);
        step();
        idle_inputs();
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL no_mispred_ignored: got %b want %b", st(), S_IDLE); end
    endtask

    task automatic test_same_cycle();
        set_port(0, mk(1'b0, 6'd9));
        set_port(1, mk(1'b0, 6'd3));
        step();
        idle_inputs();
        exp_drop++;
        n_checks++; if (st() !== S_PEND) begin n_fail++; $display("FAIL same_cycle_vld: got %b want %b", st(), S_PEND); end
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd3)) begin n_fail++; $display("FAIL same_cycle_oldest: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd3)); end
        drain();
    endtask

    task automatic test_wrap();
        set_port(0, mk(1'b0, 6'd60));
        step();
        idle_inputs();
        set_port(1, mk(1'b1, 6'd2));
        step();
        idle_inputs();
        exp_drop++;
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd60) || st() !== S_PEND) begin n_fail++; $display("FAIL wrap_younger_dropped: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd60)); end
        drain();
        set_port(0, mk(1'b1, 6'd2));
        step();
        idle_inputs();
        set_port(1, mk(1'b0, 6'd60));
        step();
        idle_inputs();
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd60) || st() !== S_PEND) begin n_fail++; $display("FAIL wrap_older_replaces: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd60)); end
        drain();
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL wrap_drained: got %b want %b", st(), S_IDLE); end
    endtask

    task automatic test_hold_replace();
        set_port(0, mk(1'b0, 6'd7));
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd7) || st() !== S_PEND) begin n_fail++; $display("FAIL hold_cycle%0d: got %h want %h", i, bus.o_squash_info, mk(1'b0, 6'd7)); end
            step();
        end
        set_port(1, mk(1'b0, 6'd4));
        step();
        idle_inputs();
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd4)) begin n_fail++; $display("FAIL replace_next_cycle: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd4)); end
        step();
        n_checks++; if (bus.o_squash_info !== mk(1'b0, 6'd4) || st() !== S_PEND) begin n_fail++; $display("FAIL replace_holds: got %h want %h", bus.o_squash_info, mk(1'b0, 6'd4)); end
        drain();
    endtask

    task automatic test_issued();
        set_port(0, mk(1'b0, 6'd10));
        step();
        idle_inputs();
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_squash_rdy = 1'b0;
        exp_mispred++;
        n_checks++; if (st() !== S_ISS) begin n_fail++; $display("FAIL issued_entered: got %b want %b", st(), S_ISS); end
        set_port(0, mk(1'b0, 6'd12));
        step();
        idle_inputs();
        exp_drop++;
        n_checks++; if (st() !== S_ISS) begin n_fail++; $display("FAIL issued_younger_dropped: got %b want %b", st(), S_ISS); end
        set_port(1, mk(1'b0, 6'd8));
        step();
        idle_inputs();
        n_checks++; if (st() !== S_PEND || bus.o_squash_info !== mk(1'b0, 6'd8)) begin n_fail++; $display("FAIL issued_older_pend: got %b/%h want %b/%h", st(), bus.o_squash_info, S_PEND, mk(1'b0, 6'd8)); end
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_squash_rdy = 1'b0;
        exp_mispred++;
        set_port(0, mk(1'b0, 6'd1));
        bus.i_redirect_done = 1'b1;
        step();
        idle_inputs();
        exp_drop++;
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL redirect_drops_input: got %b want %b", st(), S_IDLE); end
        step();
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL idle_after_redirect: got %b want %b", st(), S_IDLE); end
    endtask

    task automatic test_handshake_with_older();
        set_port(0, mk(1'b0, 6'd20));
        step();
        idle_inputs();
        set_port(1, mk(1'b0, 6'd15));
        bus.i_squash_rdy = 1'b1;
        step();
        idle_inputs();
        exp_mispred++;
        n_checks++; if (st() !== S_PEND || bus.o_squash_info !== mk(1'b0, 6'd15)) begin n_fail++; $display("FAIL hs_older_latched: got %b/%h want %b/%h", st(), bus.o_squash_info, S_PEND, mk(1'b0, 6'd15)); end
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_squash_rdy = 1'b0;
        exp_mispred++;
        set_port(0, mk(1'b0, 6'd18));
        step();
        idle_inputs();
        exp_drop++;
        n_checks++; if (st() !== S_ISS) begin n_fail++; $display("FAIL hs_filter_updated: got %b want %b", st(), S_ISS); end
        bus.i_redirect_done = 1'b1;
        step();
        bus.i_redirect_done = 1'b0;
    endtask

    task automatic test_redirect_in_pend();
        set_port(0, mk(1'b0, 6'd30));
        step();
        idle_inputs();
        bus.i_redirect_done = 1'b1;
        step();
        bus.i_redirect_done = 1'b0;
        n_checks++; if (st() !== S_PEND || bus.o_squash_info !== mk(1'b0, 6'd30)) begin n_fail++; $display("FAIL redirect_in_pend_keeps: got %b/%h want %b/%h", st(), bus.o_squash_info, S_PEND, mk(1'b0, 6'd30)); end
        drain();
    endtask

    task automatic test_counters();
`ifdef BRANCHWB_STAT_EN
        n_checks++; if (mispred_cnt !== exp_mispred) begin n_fail++; $display("FAIL mispred_cnt: got %0d want %0d", mispred_cnt, exp_mispred); end
        n_checks++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
`endif
    endtask

    task automatic test_reset_mid();
        set_port(0, mk(1'b0, 6'd3));
        step();
        idle_inputs();
        n_checks++; if (st() !== S_PEND) begin n_fail++; $display("FAIL rst_setup_pend: got %b want %b", st(), S_PEND); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_pend: got %b want %b", st(), S_IDLE); end
`ifdef BRANCHWB_STAT_EN
        n_checks++; if (mispred_cnt !== 64'd0 || drop_cnt !== 64'd0) begin n_fail++; $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", mispred_cnt, drop_cnt); end
`endif
        set_port(1, mk(1'b1, 6'd33));
        step();
        idle_inputs();
        bus.i_squash_rdy = 1'b1;
        step();
        bus.i_squash_rdy = 1'b0;
        n_checks++; if (st() !== S_ISS) begin n_fail++; $display("FAIL rst_setup_issued: got %b want %b", st(), S_ISS); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (st() !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_issued: got %b want %b", st(), S_IDLE); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_no_mispred_filter();
        test_same_cycle();
        test_wrap();
        test_hold_replace();
        test_issued();
        test_handshake_with_older();
        test_redirect_in_pend();
        test_counters();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
